// File: rtl/ma_stream_pkg.sv
// Shared types for the MA stream framer: flit field tags, parser states
// and the sideband tag bundle carried alongside each forwarded flit.
package ma_stream_pkg;

  localparam int HDR_WORDS = 4;

  typedef enum logic [3:0] {
    HDR_TEXT    = 4'd0,
    HDR_DATA    = 4'd1,
    HDR_BSS     = 4'd2,
    HDR_ENTRY   = 4'd3,
    BIN         = 4'd4,
    DESCR_SIZE  = 4'd5,
    DESCR_NTASK = 4'd6,
    DESCR_MAP   = 4'd7,
    DESCR_GRAPH = 4'd8
  } field_t;

  typedef enum logic [3:0] {
    M_HDR, M_BIN, D_SIZE, D_NTASK, D_MAP, D_GRAPH, T_HDR, T_BIN, DONE, ERROR
  } state_t;

  typedef struct packed {
    field_t     field;
    logic [7:0] task_idx;
    logic       sop;
    logic       eop;
  } flit_tag_t;

endpackage

// File: rtl/ma_flit_slice.sv
// One-entry valid/ready register holding a flit and its tags; accepts a new
// flit in the same cycle the held one leaves, so it sustains 1 flit/cycle.
module ma_flit_slice import ma_stream_pkg::*; #(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_vld,
  input  logic [FLIT_SIZE-1:0] in_data,
  input  flit_tag_t            in_tag,
  output logic                 in_rdy,
  output logic                 out_vld,
  output logic [FLIT_SIZE-1:0] out_data,
  output flit_tag_t            out_tag,
  input  logic                 out_rdy
);

  logic                 vld_p1;
  logic [FLIT_SIZE-1:0] data_p1;
  flit_tag_t            tag_p1;

  assign in_rdy   = !vld_p1 || out_rdy;
  assign out_vld  = vld_p1;
  assign out_data = data_p1;
  assign out_tag  = tag_p1;

  // p0 -> p1: output register
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '{field: HDR_TEXT, task_idx: 8'd0, sop: 1'b0, eop: 1'b0};
    end else if (in_rdy) begin
      vld_p1 <= in_vld;
      if (in_vld) begin
        data_p1 <= in_data;
        tag_p1  <= in_tag;
      end
    end
  end

endmodule

// File: rtl/ma_stream_framer.sv
// Parses an MA boot stream (mapper image, task descriptor, task images),
// tagging every flit with its field, owning task and section boundaries.
module ma_stream_framer import ma_stream_pkg::*; #(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_TASKS = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output field_t               field_o,
  output logic [7:0]           task_idx_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_t      state, state_nx, img_end;
  logic [1:0]  hdr_cnt, hdr_cnt_nx;
  logic [31:0] cnt, cnt_nx, text_q, text_nx;
  logic [7:0]  n_q, n_nx, task_q, task_nx;
  logic [32:0] hdr_sum;
  logic        slice_rdy, accept, fwd;
  field_t      fld;
  logic        sop, eop;
  flit_tag_t   tag_in, tag_out;

  // Reset must hold credit low even though the state register reads M_HDR.
  assign credit_o = rst_ni           ? 1'b0 :
                    (state == ERROR) ? 1'b1 :
                    (state == DONE)  ? 1'b0 : slice_rdy;
  assign accept   = rx_i && credit_o;
  assign done_o   = (state == DONE);
  assign err_o    = (state == ERROR);

  // Where an image ends: the mapper leads into the descriptor, task N-1 finishes the stream.
  always_comb begin
    img_end = D_SIZE;
    if (state == T_HDR || state == T_BIN)
      img_end = (task_q + 8'd1 == n_q) ? DONE : T_HDR;
  end

  always_comb begin
    state_nx   = state;
    hdr_cnt_nx = hdr_cnt;
    cnt_nx     = cnt;
    text_nx    = text_q;
    n_nx       = n_q;
    task_nx    = task_q;
    fwd        = 1'b0;
    fld        = BIN;
    sop        = 1'b0;
    eop        = 1'b0;
    hdr_sum    = {1'b0, text_q} + {1'b0, data_i[31:0]};
    if (accept) begin
      case (state)
        M_HDR, T_HDR: begin
          fwd        = 1'b1;
          fld        = field_t'({2'b00, hdr_cnt});
          sop        = (hdr_cnt == 2'd0);
          hdr_cnt_nx = hdr_cnt + 2'd1;
          if (hdr_cnt == 2'd0) text_nx = data_i[31:0];
          if (hdr_cnt == 2'd1) cnt_nx = 32'(hdr_sum >> 2);
          if (hdr_cnt == 2'(HDR_WORDS - 1)) begin
            if (cnt == 32'd0) begin
              eop      = 1'b1;
              state_nx = img_end;
              if (state == T_HDR) task_nx = task_q + 8'd1;
            end else begin
              state_nx = (state == M_HDR) ? M_BIN : T_BIN;
            end
          end
        end
        M_BIN, T_BIN: begin
          fwd    = 1'b1;
          fld    = BIN;
          cnt_nx = cnt - 32'd1;
          if (cnt == 32'd1) begin
            eop      = 1'b1;
            state_nx = img_end;
            if (state == T_BIN) task_nx = task_q + 8'd1;
          end
        end
        D_SIZE: begin
          fld = DESCR_SIZE;
          sop = 1'b1;
          if (data_i == '0 || data_i > FLIT_SIZE'(MAX_TASKS)) begin
            state_nx = ERROR;
          end else begin
            fwd      = 1'b1;
            n_nx     = data_i[7:0];
            state_nx = D_NTASK;
          end
        end
        D_NTASK: begin
          fld = DESCR_NTASK;
          if (data_i != FLIT_SIZE'(n_q)) begin
            state_nx = ERROR;
          end else begin
            fwd      = 1'b1;
            cnt_nx   = 32'd0;
            state_nx = D_MAP;
          end
        end
        D_MAP: begin
          fwd = 1'b1;
          fld = DESCR_MAP;
          if (cnt == 32'(n_q)) begin
            cnt_nx   = 32'd0;
            state_nx = D_GRAPH;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        D_GRAPH: begin
          fwd = 1'b1;
          fld = DESCR_GRAPH;
          if (cnt == 32'(n_q) - 32'd1) begin
            eop    = 1'b1;
            cnt_nx = 32'd0;
            if (n_q == 8'd1) begin
              state_nx = DONE;
            end else begin
              task_nx  = 8'd1;
              state_nx = T_HDR;
            end
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state   <= M_HDR;
      hdr_cnt <= '0;
      cnt     <= '0;
      text_q  <= '0;
      n_q     <= '0;
      task_q  <= '0;
    end else begin
      state   <= state_nx;
      hdr_cnt <= hdr_cnt_nx;
      cnt     <= cnt_nx;
      text_q  <= text_nx;
      n_q     <= n_nx;
      task_q  <= task_nx;
    end
  end

  assign tag_in = '{field: fld, task_idx: task_q, sop: sop, eop: eop};

  ma_flit_slice #(.FLIT_SIZE(FLIT_SIZE)) u_slice (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_vld   (fwd),
    .in_data  (data_i),
    .in_tag   (tag_in),
    .in_rdy   (slice_rdy),
    .out_vld  (tx_o),
    .out_data (data_o),
    .out_tag  (tag_out),
    .out_rdy  (credit_i)
  );

  assign field_o    = tag_out.field;
  assign task_idx_o = tag_out.task_idx;
  assign sop_o      = tag_out.sop;
  assign eop_o      = tag_out.eop;

endmodule

// File: tb/tb_ma_stream_framer.sv
// Bench for ma_stream_framer: streams are generated from the format rules
// together with the expected tagged output, then driven with random gaps.
module tb_ma_stream_framer;
  import ma_stream_pkg::*;

  localparam int MAXT = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_i, credit_o, tx_o, credit_i;
  logic [31:0] data_i, data_o;
  field_t      field_o;
  logic [7:0]  task_idx_o;
  logic        sop_o, eop_o, done_o, err_o;

  ma_stream_framer #(.FLIT_SIZE(32), .MAX_TASKS(MAXT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .data_i(data_i),
    .credit_o(credit_o), .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o),
    .field_o(field_o), .task_idx_o(task_idx_o), .sop_o(sop_o), .eop_o(eop_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    field_t      fld;
    logic [7:0]  tsk;
    logic        sop;
    logic        eop;
  } exp_t;

  logic [31:0] in_q[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void clear_stream();
    in_q.delete();
    exp_q.delete();
  endfunction

  function automatic void push(logic [31:0] d, field_t f, int t, bit s, bit e, bit fwd);
    in_q.push_back(d);
    if (fwd) exp_q.push_back('{data: d, fld: f, tsk: 8'(t), sop: s, eop: e});
  endfunction

  // Image = 4 header words + floor((text+data)/4) binary words.
  function automatic void add_image(logic [31:0] text, logic [31:0] data, int t);
    longint unsigned nbin;
    nbin = ({32'd0, text} + {32'd0, data}) >> 2;
    push(text, HDR_TEXT, t, 1, 0, 1);
    push(data, HDR_DATA, t, 0, 0, 1);
    push($urandom, HDR_BSS, t, 0, 0, 1);
    push($urandom, HDR_ENTRY, t, 0, nbin == 0, 1);
    for (longint unsigned i = 0; i < nbin; i++) push($urandom, BIN, t, 0, i == nbin - 1, 1);
  endfunction

  function automatic void add_descr(int n);
    push(n, DESCR_SIZE, 0, 1, 0, 1);
    push(n, DESCR_NTASK, 0, 0, 0, 1);
    for (int i = 0; i <= n; i++) push($urandom, DESCR_MAP, 0, 0, 0, 1);
    for (int i = 0; i < n; i++) push($urandom, DESCR_GRAPH, 0, 0, i == n - 1, 1);
  endfunction

  function automatic void build_valid(int n, int maxlen);
    clear_stream();
    add_image($urandom_range(maxlen), $urandom_range(maxlen), 0);
    add_descr(n);
    for (int t = 1; t < n; t++) add_image($urandom_range(maxlen), $urandom_range(maxlen), t);
  endfunction

  task automatic apply_reset();
    rx_i = 1'b0; credit_i = 1'b0; data_i = '0;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
  endtask

  // Drives in_q with random rx gaps and random downstream credit; scores every output transfer.
  task automatic run_stream(input string name, input int rx_pct, input int cr_pct,
                            input int budget, output int cycles);
    int idx = 0, got = 0;
    exp_t act;
    cycles = 0;
    while ((idx < in_q.size() || got < exp_q.size()) && cycles < budget) begin
      @(negedge clk_i);
      rx_i     = (idx < in_q.size()) && ($urandom_range(99) < rx_pct);
      data_i   = (idx < in_q.size()) ? in_q[idx] : $urandom;
      credit_i = ($urandom_range(99) < cr_pct);
      #1;
      if (tx_o && credit_i) begin
        n_checks++;
        act = '{data: data_o, fld: field_o, tsk: task_idx_o, sop: sop_o, eop: eop_o};
        if (got >= exp_q.size()) begin
          n_fail++;
          $display("FAIL %s extra_flit: got data=%h field=%0d task=%0d, required no flit",
                   name, data_o, field_o, task_idx_o);
        end else begin
          if (act !== exp_q[got]) begin
            n_fail++;
            $display("FAIL %s flit%0d: got data=%h f=%0d t=%0d sop=%b eop=%b, required data=%h f=%0d t=%0d sop=%b eop=%b",
                     name, got, act.data, act.fld, act.tsk, act.sop, act.eop,
                     exp_q[got].data, exp_q[got].fld, exp_q[got].tsk, exp_q[got].sop, exp_q[got].eop);
          end
          got++;
        end
      end
      if (rx_i && credit_o) idx++;
      cycles++;
    end
    n_checks++;
    if (cycles >= budget) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d of %0d inputs, %0d of %0d outputs, required all",
               name, idx, in_q.size(), got, exp_q.size());
    end
    @(negedge clk_i);
    rx_i = 1'b0;
    credit_i = 1'b1;
    #1;
    n_checks++;
    if (tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drained: got tx_o=%b, required 0", name, tx_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; rx_i = 1'b1; credit_i = 1'b1; data_i = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (credit_o !== 1'b0 || tx_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got credit=%b tx=%b done=%b err=%b, required 0 0 0 0",
               credit_o, tx_o, done_o, err_o);
    end
    n_checks++;
    if (data_o !== 32'd0 || field_o !== HDR_TEXT || task_idx_o !== 8'd0 || sop_o !== 1'b0 || eop_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h field=%0d task=%0d sop=%b eop=%b, required 0 HDR_TEXT 0 0 0",
               data_o, field_o, task_idx_o, sop_o, eop_o);
    end
    rx_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (credit_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_credit: got %b, required 1", credit_o);
    end
  endtask

  task automatic check_done(input string name);
    n_checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0 || credit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_done: got done=%b err=%b credit=%b, required 1 0 0", name, done_o, err_o, credit_o);
    end
  endtask

  task automatic check_err(input string name);
    n_checks++;
    if (err_o !== 1'b1 || done_o !== 1'b0 || credit_o !== 1'b1 || tx_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_err: got err=%b done=%b credit=%b tx=%b, required 1 0 1 0",
               name, err_o, done_o, credit_o, tx_o);
    end
  endtask

  task automatic test_mapper_only();
    int cyc;
    apply_reset();
    clear_stream();
    add_image(32'd8, 32'd4, 0);
    push(32'd1, DESCR_SIZE, 0, 1, 0, 1);
    push(32'd1, DESCR_NTASK, 0, 0, 0, 1);
    push(32'h0101, DESCR_MAP, 0, 0, 0, 1);
    push(32'd5, DESCR_MAP, 0, 0, 0, 1);
    push(32'd0, DESCR_GRAPH, 0, 0, 1, 1);
    run_stream("mapper_only", 100, 100, 200, cyc);
    check_done("mapper_only");
    n_checks++;
    if (cyc !== in_q.size() + 1) begin
      n_fail++;
      $display("FAIL mapper_only throughput: got %0d cycles, required %0d", cyc, in_q.size() + 1);
    end
  endtask

  task automatic test_multi_task();
    int cyc;
    apply_reset();
    clear_stream();
    add_image(32'd12, 32'd0, 0);
    add_descr(3);
    add_image(32'd4, 32'd0, 1);
    add_image(32'd4, 32'd0, 2);
    run_stream("multi_task", 100, 100, 300, cyc);
    check_done("multi_task");
  endtask

  task automatic test_zero_bin();
    int cyc;
    apply_reset();
    clear_stream();
    add_image(32'd0, 32'd0, 0);
    add_descr(2);
    add_image(32'd3, 32'd0, 1);
    run_stream("zero_bin", 80, 80, 400, cyc);
    check_done("zero_bin");
  endtask

  task automatic test_ntask_mismatch();
    int cyc;
    apply_reset();
    clear_stream();
    add_image(32'd8, 32'd0, 0);
    push(32'd3, DESCR_SIZE, 0, 1, 0, 1);
    push(32'd2, DESCR_NTASK, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) push($urandom, DESCR_MAP, 0, 0, 0, 0);
    run_stream("ntask_mismatch", 100, 100, 200, cyc);
    credit_i = 1'b0;
    #1;
    check_err("ntask_mismatch");
  endtask

  task automatic test_bad_size();
    int cyc;
    int sizes[2];
    sizes[0] = 0;
    sizes[1] = MAXT + 1;
    foreach (sizes[k]) begin
      apply_reset();
      clear_stream();
      add_image(32'd4, 32'd4, 0);
      push(sizes[k], DESCR_SIZE, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) push($urandom, DESCR_NTASK, 0, 0, 0, 0);
      run_stream($sformatf("bad_size_%0d", sizes[k]), 90, 100, 200, cyc);
      check_err($sformatf("bad_size_%0d", sizes[k]));
    end
  endtask

  task automatic test_max_tasks();
    int cyc;
    apply_reset();
    build_valid(MAXT, 3);
    run_stream("max_tasks", 100, 100, 2000, cyc);
    check_done("max_tasks");
  endtask

  task automatic test_random_streams();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      build_valid((r == 0) ? 4 : $urandom_range(1, 6), 40);
      run_stream($sformatf("random_%0d", r), $urandom_range(40, 90), 50, 8000, cyc);
      check_done($sformatf("random_%0d", r));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    apply_reset();
    build_valid(3, 20);
    run_stream("back_to_back", 100, 100, 1000, cyc);
    check_done("back_to_back");
    n_checks++;
    if (cyc !== in_q.size() + 1) begin
      n_fail++;
      $display("FAIL back_to_back throughput: got %0d cycles, required %0d", cyc, in_q.size() + 1);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc, acc;
    apply_reset();
    clear_stream();
    add_image(32'd16, 32'd0, 0);
    acc = 0;
    cyc = 0;
    while (acc < 6 && cyc < 50) begin
      @(negedge clk_i);
      rx_i = 1'b1; credit_i = 1'b1; data_i = in_q[acc];
      #1;
      if (credit_o) acc++;
      cyc++;
    end
    @(negedge clk_i);
    rx_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if (tx_o !== 1'b0 || field_o !== HDR_TEXT || data_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got tx=%b field=%0d data=%h, required 0 HDR_TEXT 0", tx_o, field_o, data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    build_valid(2, 16);
    run_stream("reset_mid", 85, 70, 2000, cyc);
    check_done("reset_mid");
  endtask

  initial begin
    test_reset();
    test_mapper_only();
    test_multi_task();
    test_zero_bin();
    test_ntask_mismatch();
    test_bad_size();
    test_max_tasks();
    test_random_streams();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_stream_framer.md
MA_STREAM_FRAMER -- requirements
Module: ma_stream_framer

Interface
REQ-001 Parameter FLIT_SIZE, default 32, sets the flit width in bits; the minimum is 32.
REQ-002 Parameter MAX_TASKS, default 32, sets the largest legal MA task count.
REQ-003 clk_i  in  1  clock; all state changes occur on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-high.
REQ-005 rx_i  in  1  upstream flit valid.
REQ-006 data_i  in  FLIT_SIZE  upstream flit.
REQ-007 credit_o  out  1  ready to upstream; a flit transfers on an edge where rx_i=1 and credit_o=1.
REQ-008 tx_o  out  1  downstream flit valid.
REQ-009 credit_i  in  1  downstream ready; a flit transfers on an edge where tx_o=1 and credit_i=1.
REQ-010 data_o  out  FLIT_SIZE  forwarded flit.
REQ-011 field_o  out  4  field tag of data_o, of type field_t.
REQ-012 task_idx_o  out  8  index of the task owning data_o; the mapper is index 0; descriptor flits carry 0.
REQ-013 sop_o / eop_o  out  1 each  first / last flit of a section (task image or descriptor).
REQ-014 done_o  out  1  full MA stream consumed.
REQ-015 err_o  out  1  sticky protocol error.

Function
REQ-016 Every accepted flit is forwarded unmodified, with its tags, through a one-entry output register; latency is 1 cycle.
REQ-017 credit_o = !tx_o || credit_i, except that in DONE credit_o=0 and in ERROR credit_o=1.
REQ-018 The FSM state advances once per accepted flit. States in order: M_HDR(4) -> M_BIN -> D_SIZE -> D_NTASK -> D_MAP -> D_GRAPH -> T_HDR(4) -> T_BIN -> DONE, plus ERROR.
REQ-019 In each HDR state, the four words are tagged HDR_TEXT, HDR_DATA, HDR_BSS and HDR_ENTRY in that order.
REQ-020 Binary word count = (text + data) >> 2, computed in 33 bits, with the 2 LSBs dropped (floor division).
REQ-021 A count of 0 skips the BIN state; the entry word then carries eop_o.
REQ-022 In D_SIZE, the word is latched as N; it is tagged DESCR_SIZE and carries sop_o.
REQ-023 N=0 or N>MAX_TASKS causes a transition to ERROR.
REQ-024 In D_NTASK, the word must equal N; a mismatch causes a transition to ERROR.
REQ-025 D_MAP accepts N+1 words (mapper address, mapper type tag, then N-1 mapping/type words), all tagged DESCR_MAP.
REQ-026 D_GRAPH accepts N words tagged DESCR_GRAPH; the last of these carries eop_o.
REQ-027 After D_GRAPH: if N=1, go to DONE; otherwise go to T_HDR with task_idx=1.
REQ-028 After each T_BIN, task_idx increments; DONE is entered after the eop_o of task N-1.
REQ-029 ERROR: err_o=1, and all input flits are accepted and dropped (no tx_o) until reset.
REQ-030 In DONE: done_o=1, and the remaining output-register flit drains normally.
REQ-031 sop_o=1 on the HDR_TEXT flit of each task image.
REQ-032 A rx_i deassertion in mid-section holds the state; no timeout applies.
REQ-033 Simultaneous accept and output transfer in the same cycle sustains 1 flit/cycle.

Reset
REQ-034 While rst_ni=1: tx_o=0, data_o=0, field_o=HDR_TEXT, task_idx_o=0, sop_o=0, eop_o=0, done_o=0, err_o=0, credit_o=0, FSM=M_HDR, all counters 0.
REQ-035 Reset asserted mid-section discards the partial stream and the output register contents; after release, parsing restarts at M_HDR.

Structure
REQ-036 Package ma_stream_pkg holds field_t (HDR_TEXT, HDR_DATA, HDR_BSS, HDR_ENTRY, BIN, DESCR_SIZE, DESCR_NTASK, DESCR_MAP, DESCR_GRAPH), the FSM state enum, and the header-word count constant (4).
REQ-037 The output register is the sub-module ma_flit_slice (data plus tags, valid/ready).
REQ-038 The FSM and counters reside in ma_stream_framer.

Verification
REQ-039 Mapper text=8, data=4, N=1, map words 0x0101 and 5, graph 0 -> 7 flits task 0 (eop on word 6), 5 descriptor flits, done_o=1, credit_o=0.
REQ-040 N=3, tasks 1 and 2 with text=4, data=0 -> task_idx_o 1 then 2, each image 5 flits with sop/eop, then done_o.
REQ-041 text=0, data=0 -> entry flit carries eop_o; next flit tagged DESCR_SIZE.
REQ-042 D_SIZE=3, D_NTASK=2 -> err_o=1 next cycle, credit_o=1, tx_o stays 0 for all further input.
REQ-043 Random credit_i (50%) and random rx_i gaps over an N=4 stream -> output sequence identical to input, no flit lost or duplicated.
REQ-044 rst_ni pulsed during M_BIN word 2, then a full stream -> output begins with HDR_TEXT, err_o=0.
